column_selector: RTL and testbench

COLUMN_SELECTOR -- requirements
Module: column_selector

---
 rtl/column_pkg.sv | 33 +++
 rtl/switch_debouncer.sv | 61 ++++++
 rtl/column_selector.sv | 132 +++++++++++++
 tb/tb_column_selector.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/column_pkg.sv
// Shared types and helpers for the column selector: FSM state encoding and
// the one-hot to 1-based column decode.
package column_pkg;

   localparam int MAX_COLS  = 15;
   localparam int MAX_COL_W = 4;

   typedef enum logic [1:0] {
      ST_RELEASE = 2'd0,
      ST_IDLE    = 2'd1,
      ST_OFFER   = 2'd2
   } col_state_e;

   // Returns the 1-based index of the single set bit, or 0 when the vector is
   // empty or has more than one bit set.
   function automatic logic [MAX_COL_W-1:0] onehot_to_col(input logic [MAX_COLS-1:0] vec);
      logic [MAX_COL_W-1:0] idx;
      int unsigned          ones;
      idx  = '0;
      ones = 0;
      for (int i = 0; i < MAX_COLS; i++) begin
         if (vec[i]) begin
            ones = ones + 1;
            idx  = MAX_COL_W'(i + 1);
         end
      end
      if (ones != 1) begin
         idx = '0;
      end
      return idx;
   endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser followed by a stability filter: the debounced vector
// only follows the synchronised switches once they hold still long enough.
module switch_debouncer
   import column_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i_sw,
   output logic [WIDTH-1:0] o_deb,
   output logic             o_settled
);

   localparam int             CNT_W = 16;
   localparam logic [CNT_W-1:0] LOAD  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_cand;
   logic [WIDTH-1:0] r_deb;
   logic [CNT_W-1:0] r_cnt;
   logic             r_settled;

   // r_cand resets to all-ones so the first post-reset sample always counts as
   // a change; a switch held through reset is then seen as already pressed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_cand    <= '1;
         r_deb     <= '0;
         r_cnt     <= '0;
         r_settled <= 1'b0;
      end else begin
         r_sync1 <= i_sw;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            if (DEBOUNCE_CYCLES == 1) begin
               r_deb     <= r_sync2;
               r_settled <= 1'b1;
               r_cnt     <= '0;
            end else begin
               r_cnt <= LOAD;
            end
         end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
               r_deb     <= r_cand;
               r_settled <= 1'b1;
            end
         end
      end
   end

   assign o_deb     = r_deb;
   assign o_settled = r_settled;

endmodule

// File: rtl/column_selector.sv
// Turns debounced column switches into a single registered move offer or a
// one-cycle reject pulse per switch activation.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   RELEASE    | waiting for all switches to read released (debounced zero)
//   IDLE       | armed; decides on the next debounced non-zero pattern
//   OFFER      | move offered; held until move_ready
module column_selector
   import column_pkg::*;
#(
   parameter int  NUM_COLS        = 8,
   parameter int  DEBOUNCE_CYCLES = 4,
   localparam int COL_W           = $clog2(NUM_COLS + 1)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_COLS-1:0] sw,
   input  logic [NUM_COLS-1:0] col_full,
   input  logic                move_ready,
   output logic                move_valid,
   output logic [COL_W-1:0]    column,
   output logic                reject_full,
   output logic                reject_multi
);

   if (NUM_COLS < 2 || NUM_COLS > MAX_COLS) begin : g_bad_num_cols
      $error("column_selector: NUM_COLS out of range 2..15");
   end
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
      $error("column_selector: DEBOUNCE_CYCLES out of range 1..65535");
   end

   logic [NUM_COLS-1:0]  w_deb;
   logic                 w_settled;
   logic [MAX_COLS-1:0]  w_deb_ext;
   logic [MAX_COL_W-1:0] w_col_raw;
   logic [COL_W-1:0]     w_deb_col;
   logic                 w_full_hit;

   col_state_e           r_state;
   logic                 r_move_valid;
   logic [COL_W-1:0]     r_column;
   logic                 r_rej_full;
   logic                 r_rej_multi;

   col_state_e           w_state_nxt;
   logic                 w_valid_nxt;
   logic [COL_W-1:0]     w_col_nxt;
   logic                 w_rej_full_nxt;
   logic                 w_rej_multi_nxt;

   switch_debouncer #(
      .WIDTH           (NUM_COLS),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_sw      (sw),
      .o_deb     (w_deb),
      .o_settled (w_settled)
   );

   assign w_deb_ext  = MAX_COLS'(w_deb);
   assign w_col_raw  = onehot_to_col(w_deb_ext);
   assign w_deb_col  = COL_W'(w_col_raw);
   // With a one-hot pattern this is exactly col_full of the selected column.
   assign w_full_hit = |(w_deb & col_full);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_RELEASE;
         r_move_valid <= 1'b0;
         r_column     <= '0;
         r_rej_full   <= 1'b0;
         r_rej_multi  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_move_valid <= w_valid_nxt;
         r_column     <= w_col_nxt;
         r_rej_full   <= w_rej_full_nxt;
         r_rej_multi  <= w_rej_multi_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_valid_nxt     = r_move_valid;
      w_col_nxt       = r_column;
      w_rej_full_nxt  = 1'b0;
      w_rej_multi_nxt = 1'b0;
      case (r_state)
         ST_RELEASE: begin
            if (w_settled && (w_deb == '0)) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (w_deb != '0) begin
               w_state_nxt = ST_RELEASE;
               if (w_deb_col == '0) begin
                  w_rej_multi_nxt = 1'b1;
               end else if (w_full_hit) begin
                  w_rej_full_nxt = 1'b1;
               end else begin
                  w_valid_nxt = 1'b1;
                  w_col_nxt   = w_deb_col;
                  w_state_nxt = ST_OFFER;
               end
            end
         end
         ST_OFFER: begin
            if (move_ready) begin
               w_valid_nxt = 1'b0;
               w_col_nxt   = '0;
               w_state_nxt = ST_RELEASE;
            end
         end
         default: begin
            w_valid_nxt = 1'b0;
            w_col_nxt   = '0;
            w_state_nxt = ST_RELEASE;
         end
      endcase
   end

   assign move_valid   = r_move_valid;
   assign column       = r_column;
   assign reject_full  = r_rej_full;
   assign reject_multi = r_rej_multi;

endmodule

// File: tb/tb_column_selector.sv
// Scenario bench for column_selector: expected offers/rejects are queued when
// switches are driven and compared when the design produces its output.
module tb_column_selector;

   localparam int EV_NONE  = 0;
   localparam int EV_OFFER = 1;
   localparam int EV_FULL  = 2;
   localparam int EV_MULTI = 3;

   typedef struct {
      int kind;
      int col;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] sw = '0;
   logic [7:0] col_full = '0;
   logic       move_ready = 1'b0;
   logic       move_valid;
   logic [3:0] column;
   logic       reject_full;
   logic       reject_multi;

   logic [11:0] sw_w = '0;
   logic [11:0] full_w = '0;
   logic        ready_w = 1'b0;
   logic        valid_w;
   logic [3:0]  col_w;
   logic        rf_w;
   logic        rm_w;

   always #5 clk = ~clk;

   column_selector dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sw           (sw),
      .col_full     (col_full),
      .move_ready   (move_ready),
      .move_valid   (move_valid),
      .column       (column),
      .reject_full  (reject_full),
      .reject_multi (reject_multi)
   );

   column_selector #(.NUM_COLS(12)) dut_wide (
      .clk          (clk),
      .reset_n      (reset_n),
      .sw           (sw_w),
      .col_full     (full_w),
      .move_ready   (ready_w),
      .move_valid   (valid_w),
      .column       (col_w),
      .reject_full  (rf_w),
      .reject_multi (rm_w)
   );

   // Returns the first output event on the 8-column instance within budget.
   task automatic wait_event(input int budget, output int kind, output int col);
      kind = EV_NONE;
      col  = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (move_valid) begin
            kind = EV_OFFER;
            col  = int'(column);
            return;
         end
         if (reject_full) begin
            kind = EV_FULL;
            return;
         end
         if (reject_multi) begin
            kind = EV_MULTI;
            return;
         end
      end
   endtask

   task automatic settle(input int n);
      @(negedge clk);
      sw         = '0;
      move_ready = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (move_valid !== 1'b0 || column !== 4'd0 || reject_full !== 1'b0 || reject_multi !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b col=%0d rf=%b rm=%b expected all 0",
                  move_valid, column, reject_full, reject_multi);
      end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (15) @(negedge clk);
      checks++;
      if (move_valid !== 1'b0 || column !== 4'd0) begin
         errors++;
         $display("FAIL reset_idle: got valid=%b col=%0d expected 0/0", move_valid, column);
      end
   endtask

   task automatic test_offer_latency;
      ev_t e;
      @(negedge clk);
      sw = 8'h04;
      exp_q.push_back('{EV_OFFER, 3});
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         if (k < 7) begin
            checks++;
            if (move_valid !== 1'b0) begin
               errors++;
               $display("FAIL latency_early edge %0d: got valid=%b expected 0", k, move_valid);
            end
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (move_valid !== 1'b1 || int'(column) != e.col) begin
               errors++;
               $display("FAIL latency_edge7: got valid=%b col=%0d expected valid=1 col=%0d",
                        move_valid, column, e.col);
            end
         end
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checks++;
         if (move_valid !== 1'b1 || column !== 4'd3) begin
            errors++;
            $display("FAIL offer_hold cycle %0d: got valid=%b col=%0d expected 1/3", k, move_valid, column);
         end
      end
      @(negedge clk);
      move_ready = 1'b1;
      sw = '0;
      @(posedge clk); #1;
      checks++;
      if (move_valid !== 1'b0 || column !== 4'd0) begin
         errors++;
         $display("FAIL offer_accept: got valid=%b col=%0d expected 0/0", move_valid, column);
      end
      settle(12);
   endtask

   task automatic test_glitch;
      int kind, col;
      @(negedge clk);
      sw = 8'h01;
      repeat (3) @(negedge clk);
      sw = '0;
      wait_event(25, kind, col);
      checks++;
      if (kind != EV_NONE) begin
         errors++;
         $display("FAIL glitch_ignored: got event %0d expected %0d", kind, EV_NONE);
      end
   endtask

   task automatic test_multi;
      int  kind, col;
      ev_t e;
      @(negedge clk);
      sw = 8'h03;
      exp_q.push_back('{EV_MULTI, 0});
      wait_event(20, kind, col);
      e = exp_q.pop_front();
      checks++;
      if (kind != e.kind) begin
         errors++;
         $display("FAIL multi_reject: got event %0d expected %0d", kind, e.kind);
      end
      @(posedge clk); #1;
      checks++;
      if (reject_multi !== 1'b0) begin
         errors++;
         $display("FAIL multi_one_cycle: got rm=%b expected 0", reject_multi);
      end
      wait_event(20, kind, col);
      checks++;
      if (kind != EV_NONE) begin
         errors++;
         $display("FAIL multi_held_quiet: got event %0d expected %0d", kind, EV_NONE);
      end
      settle(12);
   endtask

   task automatic test_full;
      int  kind, col;
      ev_t e;
      @(negedge clk);
      col_full = 8'h80;
      sw = 8'h80;
      exp_q.push_back('{EV_FULL, 0});
      wait_event(20, kind, col);
      e = exp_q.pop_front();
      checks++;
      if (kind != e.kind) begin
         errors++;
         $display("FAIL full_reject: got event %0d expected %0d", kind, e.kind);
      end
      @(posedge clk); #1;
      checks++;
      if (reject_full !== 1'b0 || move_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_one_cycle: got rf=%b valid=%b expected 0/0", reject_full, move_valid);
      end
      @(negedge clk);
      sw = '0;
      wait_event(15, kind, col);
      checks++;
      if (kind != EV_NONE) begin
         errors++;
         $display("FAIL full_release_quiet: got event %0d expected %0d", kind, EV_NONE);
      end
      @(negedge clk);
      col_full = '0;
      sw = 8'h02;
      exp_q.push_back('{EV_OFFER, 2});
      wait_event(20, kind, col);
      e = exp_q.pop_front();
      checks++;
      if (kind != e.kind || col != e.col) begin
         errors++;
         $display("FAIL full_offer_col2: got event %0d col %0d expected %0d col %0d", kind, col, e.kind, e.col);
      end
      @(negedge clk);
      col_full = 8'hFF;
      sw = 8'h08;
      for (int k = 0; k < 12; k++) begin
         if (k == 6) sw = '0;
         @(posedge clk); #1;
         checks++;
         if (move_valid !== 1'b1 || column !== 4'd2) begin
            errors++;
            $display("FAIL offer_persists cycle %0d: got valid=%b col=%0d expected 1/2", k, move_valid, column);
         end
         @(negedge clk);
      end
      move_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (move_valid !== 1'b0 || column !== 4'd0) begin
         errors++;
         $display("FAIL full_accept: got valid=%b col=%0d expected 0/0", move_valid, column);
      end
      @(negedge clk);
      move_ready = 1'b0;
      col_full = '0;
      wait_event(15, kind, col);
      checks++;
      if (kind != EV_NONE) begin
         errors++;
         $display("FAIL full_after_accept_quiet: got event %0d expected %0d", kind, EV_NONE);
      end
   endtask

   task automatic test_reset_held;
      int  kind, col;
      ev_t e;
      @(negedge clk);
      sw = 8'h10;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      wait_event(30, kind, col);
      checks++;
      if (kind != EV_NONE) begin
         errors++;
         $display("FAIL held_through_reset: got event %0d expected %0d", kind, EV_NONE);
      end
      @(negedge clk);
      sw = '0;
      wait_event(15, kind, col);
      checks++;
      if (kind != EV_NONE) begin
         errors++;
         $display("FAIL held_release_quiet: got event %0d expected %0d", kind, EV_NONE);
      end
      @(negedge clk);
      sw = 8'h10;
      exp_q.push_back('{EV_OFFER, 5});
      wait_event(20, kind, col);
      e = exp_q.pop_front();
      checks++;
      if (kind != e.kind || col != e.col) begin
         errors++;
         $display("FAIL repress_offer: got event %0d col %0d expected %0d col %0d", kind, col, e.kind, e.col);
      end
      @(negedge clk);
      move_ready = 1'b1;
      settle(12);
   endtask

   task automatic test_reset_mid_offer;
      int  kind, col;
      ev_t e;
      @(negedge clk);
      sw = 8'h40;
      exp_q.push_back('{EV_OFFER, 7});
      wait_event(20, kind, col);
      e = exp_q.pop_front();
      checks++;
      if (kind != e.kind || col != e.col) begin
         errors++;
         $display("FAIL mid_offer_setup: got event %0d col %0d expected %0d col %0d", kind, col, e.kind, e.col);
      end
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (move_valid !== 1'b0 || column !== 4'd0) begin
         errors++;
         $display("FAIL async_reset_offer: got valid=%b col=%0d expected 0/0", move_valid, column);
      end
      sw = '0;
      @(negedge clk);
      reset_n = 1'b1;
      settle(15);
   endtask

   task automatic test_wide;
      ev_t e;
      int  seen;
      @(negedge clk);
      sw_w = 12'h800;
      exp_q.push_back('{EV_OFFER, 12});
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(posedge clk); #1;
         if (valid_w) seen = 1;
      end
      e = exp_q.pop_front();
      checks++;
      if (valid_w !== 1'b1 || int'(col_w) != e.col) begin
         errors++;
         $display("FAIL wide_col12: got valid=%b col=%0d expected valid=1 col=%0d", valid_w, col_w, e.col);
      end
      @(negedge clk);
      ready_w = 1'b1;
      sw_w = '0;
      @(posedge clk); #1;
      checks++;
      if (valid_w !== 1'b0 || col_w !== 4'd0) begin
         errors++;
         $display("FAIL wide_accept: got valid=%b col=%0d expected 0/0", valid_w, col_w);
      end
      @(negedge clk);
      ready_w = 1'b0;
   endtask

   task automatic test_back_to_back;
      int  kind, col;
      ev_t e;
      logic [7:0] pat;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         pat = 8'(1 << c);
         sw = pat;
         exp_q.push_back('{EV_OFFER, c + 1});
         wait_event(20, kind, col);
         e = exp_q.pop_front();
         checks++;
         if (kind != e.kind || col != e.col) begin
            errors++;
            $display("FAIL b2b_offer %0d: got event %0d col %0d expected %0d col %0d",
                     c, kind, col, e.kind, e.col);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         @(negedge clk);
         move_ready = 1'b1;
         sw = '0;
         @(posedge clk); #1;
         checks++;
         if (move_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept %0d: got valid=%b expected 0", c, move_valid);
         end
         @(negedge clk);
         move_ready = 1'b0;
         repeat (10) @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_offer_latency();
      test_glitch();
      test_multi();
      test_full();
      test_reset_held();
      test_reset_mid_offer();
      test_wide();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
